// File: rtl/riscv_crypto_fu_subword_seq_pkg.sv
// rtl/riscv_crypto_fu_subword_seq_pkg.sv - op/state encodings and S-box helper functions for the SubWord sequencer
package riscv_crypto_fu_subword_seq_pkg;

  localparam logic [2:0] SUBW_AES_FWD = 3'd0;
  localparam logic [2:0] SUBW_AES_INV = 3'd1;
  localparam logic [2:0] SUBW_SM4     = 3'd2;
  localparam logic [2:0] SUBW_SM4_ED  = 3'd3;
  localparam logic [2:0] SUBW_SM4_KS  = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SM4_SBOX = {
    128'hD690E9FECCE13DB716B614C228FB2C05,
    128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62,
    128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8,
    128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887,
    128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1,
    128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F,
    128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8,
    128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684,
    128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 in GF(2^8); maps zero to zero as the AES S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes_fwd(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] sm4_sub(input logic [7:0] a);
    return SM4_SBOX[{~a, 3'b111} -: 8];
  endfunction

endpackage

// File: rtl/riscv_crypto_aes_sm4_sbox.sv
// rtl/riscv_crypto_aes_sm4_sbox.sv - combined AES forward/inverse and SM4 byte S-box
module riscv_crypto_aes_sm4_sbox
  import riscv_crypto_fu_subword_seq_pkg::*;
(
  input  logic       aes,
  input  logic       dec,
  input  logic       sm4,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_comb begin
    dout = 8'h00;
    if (sm4) begin
      dout = sm4_sub(din);
    end else if (aes) begin
      dout = dec ? aes_inv(din) : aes_fwd(din);
    end
  end

endmodule

// File: rtl/riscv_crypto_sm4_linear.sv
// rtl/riscv_crypto_sm4_linear.sv - SM4 linear layers L (encrypt/decrypt) and L' (key schedule)
module riscv_crypto_sm4_linear (
  input  logic        ks,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return 32'((x << n) | (x >> (32 - n)));
  endfunction

  assign dout = ks ? (din ^ rotl32(din, 13) ^ rotl32(din, 23))
                   : (din ^ rotl32(din, 2) ^ rotl32(din, 10) ^ rotl32(din, 18) ^ rotl32(din, 24));

endmodule

// File: rtl/riscv_crypto_fu_subword_seq.sv
// rtl/riscv_crypto_fu_subword_seq.sv - multi-cycle SubWord sequencer sharing SBOX_PER_CYCLE S-boxes
module riscv_crypto_fu_subword_seq
  import riscv_crypto_fu_subword_seq_pkg::*;
#(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rd,
  output logic        out_err
);

  localparam int NBEATS = 4 / SBOX_PER_CYCLE;

  logic [1:0]  state;
  logic [1:0]  idx;
  logic [31:0] work;
  logic [2:0]  op_q;
  logic [7:0]  sb_in  [SBOX_PER_CYCLE];
  logic [7:0]  sb_out [SBOX_PER_CYCLE];
  logic [31:0] merged;
  logic [31:0] lin_out;
  logic [31:0] result;
  logic        op_aes, op_dec, op_sm4, op_ks, op_lin, op_rsvd, last_beat;

  assign op_rsvd   = op_q > SUBW_SM4_KS;
  assign op_aes    = (op_q == SUBW_AES_FWD) || (op_q == SUBW_AES_INV);
  assign op_dec    = op_q == SUBW_AES_INV;
  assign op_ks     = op_q == SUBW_SM4_KS;
  assign op_lin    = (op_q == SUBW_SM4_ED) || op_ks;
  assign op_sm4    = (op_q == SUBW_SM4) || op_lin;
  assign last_beat = idx == 2'((NBEATS - 1) * SBOX_PER_CYCLE);

  assign in_ready  = (state == ST_IDLE) && !flush;
  assign out_valid = state == ST_DONE;

  for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_sbox
    logic [1:0] lane;
    assign lane     = idx + 2'(g);
    assign sb_in[g] = work[{lane, 3'b000} +: 8];
    riscv_crypto_aes_sm4_sbox u_sbox (
      .aes  (op_aes),
      .dec  (op_dec),
      .sm4  (op_sm4),
      .din  (sb_in[g]),
      .dout (sb_out[g])
    );
  end

  // Current beat's S-box bytes are folded in so the last beat can finish without an extra cycle.
  always_comb begin
    merged = work;
    for (int g = 0; g < SBOX_PER_CYCLE; g++) begin
      merged[{idx + 2'(g), 3'b000} +: 8] = sb_out[g];
    end
  end

  riscv_crypto_sm4_linear u_linear (
    .ks   (op_ks),
    .din  (merged),
    .dout (lin_out)
  );

  assign result = op_lin ? lin_out : merged;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state   <= ST_IDLE;
      idx     <= 2'd0;
      work    <= 32'h0;
      op_q    <= 3'd0;
      out_rd  <= 32'h0;
      out_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state <= ST_BUSY;
            idx   <= 2'd0;
            work  <= in_rs1;
            op_q  <= in_op;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (op_rsvd) begin
            state   <= ST_DONE;
            out_rd  <= 32'h0;
            out_err <= 1'b1;
          end else begin
            work <= merged;
            idx  <= idx + 2'(SBOX_PER_CYCLE);
            if (last_beat) begin
              state   <= ST_DONE;
              out_rd  <= result;
              out_err <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (flush || out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_crypto_fu_subword_seq.sv
// tb/tb_riscv_crypto_fu_subword_seq.sv - scoreboard bench driving P=1, P=2 and P=4 instances
module tb_riscv_crypto_fu_subword_seq;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [2:0]  in_op     [3];
  logic [31:0] in_rs1    [3];
  logic        flush     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] out_rd    [3];
  logic        out_err   [3];
  logic        prev_valid[3];

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[3][$];
  int   passed = 0;
  int   total  = 0;
  int   ncyc   = 0;

  always #5 g_clk = ~g_clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    riscv_crypto_fu_subword_seq #(.SBOX_PER_CYCLE(1 << d)) u_dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .in_valid  (in_valid[d]),
      .in_ready  (in_ready[d]),
      .in_op     (in_op[d]),
      .in_rs1    (in_rs1[d]),
      .flush     (flush[d]),
      .out_valid (out_valid[d]),
      .out_ready (out_ready[d]),
      .out_rd    (out_rd[d]),
      .out_err   (out_err[d])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Monitor: latency checked when out_valid rises, data checked at the handshake.
  always @(negedge g_clk) begin
    exp_t e;
    ncyc++;
    for (int d = 0; d < 3; d++) begin
      if (g_reset) begin
        prev_valid[d] = 1'b0;
      end else begin
        if (out_valid[d] && !prev_valid[d]) begin
          if (exp_q[d].size() == 0)
            check($sformatf("unexpected_out_valid_p%0d", 1 << d), {31'b0, out_valid[d]}, 32'd0);
          else
            check($sformatf("latency_p%0d", 1 << d), ncyc - exp_q[d][0].acc - 1, exp_q[d][0].lat);
        end
        if (out_valid[d] && out_ready[d] && exp_q[d].size() != 0) begin
          e = exp_q[d].pop_front();
          check($sformatf("out_rd_p%0d", 1 << d), out_rd[d], e.rd);
          check($sformatf("out_err_p%0d", 1 << d), {31'b0, out_err[d]}, {31'b0, e.err});
        end
        prev_valid[d] = out_valid[d];
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] rs1, input bit push,
                       input logic [31:0] erd, input logic eerr, input int elat);
    bit   rdy;
    bit   done;
    exp_t e;
    done = 1'b0;
    @(posedge g_clk); #1;
    in_valid[d] = 1'b1;
    in_op[d]    = op;
    in_rs1[d]   = rs1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge g_clk);
      rdy = in_ready[d];
      @(posedge g_clk);
      if (rdy) begin
        done = 1'b1;
        if (push) begin
          e.rd  = erd;
          e.err = eerr;
          e.lat = elat;
          e.acc = ncyc;
          exp_q[d].push_back(e);
        end
      end
    end
    #1;
    in_valid[d] = 1'b0;
    in_op[d]    = 3'd7;
    in_rs1[d]   = ~rs1;
    if (!done) check($sformatf("accept_p%0d", 1 << d), {31'b0, done}, 32'd1);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    check($sformatf("drain_p%0d", 1 << d), exp_q[d].size(), 32'd0);
  endtask

  logic [2:0]  v_op [6] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd4, 3'd0};
  logic [31:0] v_rs [6] = '{32'h637C777B, 32'h00000000, 32'h00000000, 32'h01010101, 32'h00000000, 32'h00010203};
  logic [31:0] v_rd [6] = '{32'h00010203, 32'hD6D6D6D6, 32'h5B5B5B5B, 32'h90909090, 32'h67676767, 32'h637C777B};

  initial begin
    int n;
    g_reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]   = 1'b0;
      in_op[d]      = 3'd0;
      in_rs1[d]     = 32'h0;
      flush[d]      = 1'b0;
      out_ready[d]  = 1'b1;
      prev_valid[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      check("reset_in_ready", {31'b0, in_ready[d]}, 32'd1);
      check("reset_out_valid", {31'b0, out_valid[d]}, 32'd0);
      check("reset_out_rd", out_rd[d], 32'h0);
      check("reset_out_err", {31'b0, out_err[d]}, 32'd0);
    end
    @(posedge g_clk); #1;
    g_reset = 1'b0;

    // Basic AES forward with in_ready low through the busy cycles.
    issue(0, 3'd0, 32'h00010203, 1, 32'h637C777B, 1'b0, 4);
    @(negedge g_clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge g_clk);
      check($sformatf("in_ready_cycle%0d", k), {31'b0, in_ready[0]}, 32'd0);
    end
    drain(0);

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 6; i++) begin
        issue(d, v_op[i], v_rs[i], 1, v_rd[i], 1'b0, 4 >> d);
        drain(d);
      end
    end

    // Back-pressure holds the result.
    @(posedge g_clk); #1;
    out_ready[0] = 1'b0;
    issue(0, 3'd0, 32'h53535353, 1, 32'hEDEDEDED, 1'b0, 4);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge g_clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge g_clk);
      check("bp_out_valid", {31'b0, out_valid[0]}, 32'd1);
      check("bp_out_rd", out_rd[0], 32'hEDEDEDED);
      check("bp_in_ready", {31'b0, in_ready[0]}, 32'd0);
    end
    @(posedge g_clk); #1;
    out_ready[0] = 1'b1;
    @(negedge g_clk);
    @(negedge g_clk);
    check("bp_release_out_valid", {31'b0, out_valid[0]}, 32'd0);
    check("bp_release_in_ready", {31'b0, in_ready[0]}, 32'd1);
    drain(0);

    // Reserved op, then a normal op clears out_err.
    issue(0, 3'd6, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 1);
    drain(0);
    issue(0, 3'd0, 32'h00010203, 1, 32'h637C777B, 1'b0, 4);
    drain(0);

    // Flush in IDLE blocks acceptance.
    @(posedge g_clk); #1;
    flush[0] = 1'b1; in_valid[0] = 1'b1; in_op[0] = 3'd0;
    @(negedge g_clk);
    check("idle_flush_in_ready", {31'b0, in_ready[0]}, 32'd0);
    @(posedge g_clk); #1;
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    @(negedge g_clk);
    check("idle_flush_no_accept", {31'b0, in_ready[0]}, 32'd1);

    // Flush during beat 2.
    issue(0, 3'd0, 32'hAABBCCDD, 0, 32'h0, 1'b0, 0);
    @(posedge g_clk);
    @(posedge g_clk); #1;
    flush[0] = 1'b1;
    @(posedge g_clk); #1;
    flush[0] = 1'b0;
    @(negedge g_clk);
    check("flush_out_valid", {31'b0, out_valid[0]}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready[0]}, 32'd1);
    repeat (8) @(negedge g_clk);
    issue(0, 3'd0, 32'h00010203, 1, 32'h637C777B, 1'b0, 4);
    drain(0);

    // Asynchronous reset mid-operation.
    issue(0, 3'd0, 32'h12345678, 0, 32'h0, 1'b0, 0);
    @(posedge g_clk);
    @(posedge g_clk); #1;
    g_reset = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready[0]}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid[0]}, 32'd0);
    check("rst_out_rd", out_rd[0], 32'h0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    repeat (6) @(negedge g_clk);
    issue(0, 3'd0, 32'h00010203, 1, 32'h637C777B, 1'b0, 4);
    drain(0);

    repeat (3) @(negedge g_clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
